// File: rtl/icache_ctrl_pkg.sv
// Shared constants and types for the 2-way instruction cache controller.
// Holds the state encoding, array geometry and memory read-type encodings.
package icache_ctrl_pkg;

  localparam int INDEX_W    = 8;
  localparam int TAG_W      = 20;
  localparam int OFFSET_W   = 4;
  localparam int NUM_SETS   = 1 << INDEX_W;
  localparam int LINE_WORDS = 4;
  localparam int WORD_SEL_W = 2;
  localparam int LINE_W     = 32 * LINE_WORDS;

  localparam logic RD_TYPE_WORD = 1'b0;
  localparam logic RD_TYPE_LINE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_UNCACHED
  } state_e;

endpackage

// File: rtl/icache_way.sv
// One cache way: tag, valid and data arrays with a registered read port.
// Reads forward same-cycle writes so a line completed on ret_last is visible next cycle.
module icache_way
  import icache_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic                  data_we,
  input  logic [WORD_SEL_W-1:0] data_word,
  input  logic [31:0]           data_wdata,
  input  logic                  tag_we,
  input  logic [TAG_W-1:0]      tag_wdata
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic                rd_valid_q, rd_valid_d;
  logic [TAG_W-1:0]    tag_mem [NUM_SETS];
  logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;
  logic                same_set;

  assign same_set = (wr_index == rd_index);

  // Valid bits live in flops so reset can clear every set at once.
  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[wr_index] = 1'b1;
    rd_valid_d = valid_q[rd_index] | (tag_we & same_set);
    rd_tag_d   = (tag_we && same_set) ? tag_wdata : tag_mem[rd_index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[wr_index] <= tag_wdata;
    rd_tag_q <= rd_tag_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [31:0] data_mem [NUM_SETS];
      logic [31:0] word_q, word_d;
      logic        word_we;

      assign word_we = data_we && (data_word == WORD_SEL_W'(gi));

      always_comb begin
        word_d = (word_we && same_set) ? data_wdata : data_mem[rd_index];
      end

      always_ff @(posedge clk) begin
        if (word_we) data_mem[wr_index] <= data_wdata;
        word_q <= word_d;
      end

      assign rd_line[gi*32 +: 32] = word_q;
    end
  endgenerate

  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;

endmodule

// File: rtl/icache_ctrl.sv
// 2-way set-associative instruction cache controller with line refill and uncached bypass.
// Arrays are read in the accept cycle so LOOKUP resolves hit/miss one cycle after acceptance.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [7:0]  inst_index,
  input  logic [19:0] inst_tag,
  input  logic [3:0]  inst_offset,
  input  logic        inst_uncached,
  output logic        icache_busy,
  output logic [31:0] inst_rdata,
  output logic        inst_rdata_valid,
  output logic        rd_req,
  output logic        rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int CNT_W = $clog2(BURST_LEN);

  state_e                state_q, state_d;
  logic [INDEX_W-1:0]    index_q, index_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [WORD_SEL_W-1:0] word_q, word_d;
  logic                  victim_q, victim_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sent_q, sent_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_SETS-1:0]   lru_q, lru_d;

  logic                  accept, data_we, tag_we;
  logic [INDEX_W-1:0]    rd_index;
  logic [1:0]            way_valid, way_hit;
  logic [1:0][TAG_W-1:0] way_tag;
  logic [1:0][LINE_W-1:0] way_line;
  logic [LINE_W-1:0]     hit_line;
  logic [31:0]           hit_word;
  logic                  unused_offset_bits;

  assign unused_offset_bits = ^inst_offset[1:0];
  assign rd_index = accept ? inst_index : index_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      icache_way u_way (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (rd_index),
        .rd_valid   (way_valid[gi]),
        .rd_tag     (way_tag[gi]),
        .rd_line    (way_line[gi]),
        .wr_index   (index_q),
        .data_we    (data_we && (victim_q == 1'(gi))),
        .data_word  (cnt_q),
        .data_wdata (ret_data),
        .tag_we     (tag_we && (victim_q == 1'(gi))),
        .tag_wdata  (tag_q)
      );
      assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == tag_q);
    end
  endgenerate

  assign hit_line = way_hit[1] ? way_line[1] : way_line[0];
  assign hit_word = hit_line[{word_q, 5'b0} +: 32];

  always_comb begin
    state_d          = state_q;
    index_d          = index_q;
    tag_d            = tag_q;
    word_d           = word_q;
    victim_d         = victim_q;
    cnt_d            = cnt_q;
    sent_d           = sent_q;
    lru_d            = lru_q;
    icache_busy      = 1'b0;
    inst_rdata_valid = 1'b0;
    inst_rdata       = rdata_q;
    rd_req           = 1'b0;
    rd_type          = RD_TYPE_LINE;
    rd_addr          = {tag_q, index_q, 4'b0};
    accept           = 1'b0;
    data_we          = 1'b0;
    tag_we           = 1'b0;

    unique case (state_q)
      ST_IDLE: accept = inst_valid;
      ST_LOOKUP: begin
        if (|way_hit) begin
          inst_rdata_valid = 1'b1;
          inst_rdata       = hit_word;
          // LRU bit names the way to evict next: the one not just used.
          lru_d[index_q]   = way_hit[0];
          accept           = inst_valid;
          state_d          = ST_IDLE;
        end else begin
          icache_busy = 1'b1;
          if (!way_valid[0])      victim_d = 1'b0;
          else if (!way_valid[1]) victim_d = 1'b1;
          else                    victim_d = lru_q[index_q];
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        icache_busy = 1'b1;
        rd_req      = 1'b1;
        if (rd_rdy) begin
          cnt_d   = '0;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        icache_busy = 1'b1;
        if (ret_valid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (ret_last) begin
            tag_we  = 1'b1;
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_UNCACHED: begin
        icache_busy = 1'b1;
        rd_req      = !sent_q;
        rd_type     = RD_TYPE_WORD;
        rd_addr     = {tag_q, index_q, word_q, 2'b00};
        if (rd_rdy && !sent_q) sent_d = 1'b1;
        if (sent_q && ret_valid && ret_last) begin
          inst_rdata_valid = 1'b1;
          inst_rdata       = ret_data;
          sent_d           = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      index_d = inst_index;
      tag_d   = inst_tag;
      word_d  = inst_offset[3:2];
      state_d = inst_uncached ? ST_UNCACHED : ST_LOOKUP;
    end
  end

  assign rdata_d = inst_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      tag_q    <= '0;
      word_q   <= '0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
      sent_q   <= 1'b0;
      rdata_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      tag_q    <= tag_d;
      word_q   <= word_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
      sent_q   <= sent_d;
      rdata_q  <= rdata_d;
      lru_q    <= lru_d;
    end
  end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter: BURST_LEN, 4, words per line refill; fixed at 4 to match the 4-bit inst_offset.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 inst_valid  input  1  fetch request strobe from pre-IF stage.
REQ-005 inst_index  input  8  set index (physical addr [11:4]).
REQ-006 inst_tag  input  20  physical tag (addr [31:12]).
REQ-007 inst_offset  input  4  byte offset in line; [3:2] selects word; [1:0] ignored.
REQ-008 inst_uncached  input  1  request bypasses cache (single-word read, no allocate).
REQ-009 icache_busy  output  1  cache cannot accept a request this cycle.
REQ-010 inst_rdata  output  32  fetched instruction word.
REQ-011 inst_rdata_valid  output  1  inst_rdata valid this cycle (one-cycle pulse).
REQ-012 rd_req  output  1  memory read request, held until rd_rdy.
REQ-013 rd_type  output  1  0 = single word, 1 = BURST_LEN-word line.
REQ-014 rd_addr  output  32  read address; line-aligned ([3:0]=0) for line reads, word-aligned for single reads.
REQ-015 rd_rdy  input  1  memory accepts rd_req this cycle.
REQ-016 ret_valid  input  1  return data beat valid.
REQ-017 ret_last  input  1  final return beat.
REQ-018 ret_data  input  32  return data beat.

Function
REQ-019 Organisation: 2-way set-associative, 256 sets, 16-byte lines, 1 LRU bit per set, 1 valid bit per way per set.
REQ-020 States: IDLE, LOOKUP, MISS, REFILL, UNCACHED.
REQ-021 Request accepted when inst_valid=1 and icache_busy=0; index/tag/offset/uncached are registered and state goes to LOOKUP (cached) or UNCACHED (uncached).
REQ-022 LOOKUP: tag compared against both ways; hit gives inst_rdata_valid=1 with the selected word in the same cycle; the set's LRU bit is updated to the other way; state goes to IDLE or, if a new request is accepted that cycle, stays in LOOKUP.
REQ-023 Hit latency: 1 cycle from acceptance to inst_rdata_valid; back-to-back hits give one word per cycle.
REQ-024 icache_busy = (LOOKUP and miss) or state in {MISS, REFILL, UNCACHED}; it is combinational from the tag compare.
REQ-025 LOOKUP miss: victim = invalid way if any (way0 first), else the LRU way; state goes to MISS.
REQ-026 MISS: rd_req=1, rd_type=1, rd_addr={tag,index,4'b0}; on rd_rdy the state goes to REFILL.
REQ-027 REFILL: each ret_valid writes ret_data into the victim line at word = beat counter (0..3), then the counter increments; on ret_last the tag is written, the valid bit is set, and the state returns to LOOKUP with the saved request, which then hits.
REQ-028 UNCACHED: rd_req=1, rd_type=0, rd_addr={tag,index,offset[3:2],2'b00} until rd_rdy; the beat with ret_valid and ret_last drives inst_rdata=ret_data with inst_rdata_valid=1 in the same cycle; no array write; state goes to IDLE.
REQ-029 Requests presented while busy are ignored; the requester must hold or re-issue them.
REQ-030 A memory transaction in flight cannot be aborted; a flush upstream has no input here and the refill completes.
REQ-031 Beat counter wraps 3->0; ret_valid outside REFILL/UNCACHED is ignored.
REQ-032 Outside the cases in REQ-022 and REQ-028, inst_rdata_valid=0 and inst_rdata holds its last value.

Reset
REQ-033 On reset: state IDLE; all valid bits 0; LRU bits 0; beat counter 0; rd_req=0; inst_rdata_valid=0; icache_busy=0; inst_rdata=0.
REQ-034 Reset during MISS/REFILL/UNCACHED abandons the transaction and ignores later return beats until a new rd_req is issued.

Structure
REQ-035 State encoding, line/index/tag width constants and the rd_type encodings belong in global_defines.vh.
REQ-036 One sub-module, icache_way, holds the tag, valid and data arrays for one way; it is instantiated twice.

Verification
REQ-037 Cold miss: reset, request tag=0x12345 index=0x10 offset=0x8 -> rd_req with rd_addr=0x12345100, rd_type=1; 4 beats A0..A3 -> inst_rdata=A2 with inst_rdata_valid=1 one cycle after ret_last.
REQ-038 Hit stream: after REQ-037, offsets 0x0, 0x4, 0xC on consecutive cycles -> A0, A1, A3 on consecutive cycles; icache_busy stays 0.
REQ-039 LRU replace: fill way0 with tag 0x1 and way1 with tag 0x2 in set 5, hit tag 0x1, then miss tag 0x3 -> way1 is replaced; tag 0x1 still hits.
REQ-040 Uncached: request with inst_uncached=1 at 0xBFC00004 -> rd_type=0, rd_addr=0xBFC00004; one beat 0xDEADBEEF -> inst_rdata=0xDEADBEEF; a later cached lookup of the same address misses.
REQ-041 Busy drop: inst_valid held during a refill -> no second rd_req; the held request is serviced after the refill completes.
REQ-042 Reset mid-REFILL after 2 beats -> icache_busy=0 the next cycle; a lookup of that line misses.
